// File: rtl/vga_sink_checker.sv
// vga_sink_checker: receive-side VGA timing checker.
// Samples hsync/vsync/RGB on pixel ticks and recovers the pixel position.
// Measures line and frame timing against the parameterised mode, and declares
// lock after consecutive good frames. Also produces a per-frame rotate-xor
// checksum of the visible pixels.
// Optional feature: define VGA_BLANK_CHECK_EN to count non-black pixels seen
// during blanking; without it blank_err_cnt is tied to 0.
module vga_sink_checker #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BP            = 48,
    parameter int unsigned H_TOTAL         = 800,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BP            = 33,
    parameter int unsigned V_TOTAL         = 525,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        locked,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active,
    output logic [10:0] h_period,
    output logic [10:0] v_period,
    output logic        line_err,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] blank_err_cnt
);

    localparam int unsigned CW        = 11;
    localparam int unsigned H_OFF     = H_SYNC + H_BP;
    localparam int unsigned V_OFF     = V_SYNC + V_BP;
    localparam int unsigned H_END     = H_OFF + H_ACTIVE;
    localparam int unsigned V_END     = V_OFF + V_ACTIVE;
    localparam int unsigned TMO_TICKS = 2 * H_TOTAL;
    localparam int unsigned GOOD_NEED = 2;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic          POL     = (SYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state;

    // Sync history (stored as "active" level, independent of polarity)
    logic          hs_q;
    logic          vs_q;

    // Timing counters
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] hw_cnt;
    logic [CW-1:0] line_cnt;

    // Lock tracking
    logic [1:0]    good_cnt;
    logic          frame_bad;
    logic          skip_line;

    // Running checksum of the frame in progress
    logic [15:0]   sum;

    // Combinational per-tick decode
    logic          hs_act;
    logic          vs_act;
    logic          h_lead;
    logic          v_lead;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] l_inc;
    logic [CW-1:0] l_pos;
    logic [9:0]    x_nxt;
    logic [9:0]    y_nxt;
    logic          act_nxt;
    logic          line_fail;
    logic          frame_good;
    logic          tmo;

    // Sync polarity normalisation and leading-edge detection
    always_comb begin
        hs_act = hsync ^ POL;
        vs_act = vsync ^ POL;
        h_lead = pix_en & hs_act & ~hs_q;
        v_lead = pix_en & vs_act & ~vs_q;
    end

    // Position of the current tick: hsync edge starts column 0, vsync edge row 0
    always_comb begin
        h_nxt = h_cnt;
        if (h_lead) begin
            h_nxt = '0;
        end else if (h_cnt != CNT_MAX) begin
            h_nxt = h_cnt + CW'(1);
        end

        l_inc = line_cnt;
        if (h_lead && (line_cnt != CNT_MAX)) begin
            l_inc = line_cnt + CW'(1);
        end
        l_pos = v_lead ? '0 : l_inc;

        x_nxt = 10'(h_nxt - CW'(H_OFF));
        y_nxt = 10'(l_pos - CW'(V_OFF));

        act_nxt = (state != HUNT)
               && (h_nxt >= CW'(H_OFF)) && (h_nxt < CW'(H_END))
               && (l_pos >= CW'(V_OFF)) && (l_pos < CW'(V_END));
    end

    // Line/frame verdicts and the loss-of-hsync timeout
    always_comb begin
        line_fail  = h_lead && (state != HUNT) && !skip_line
                  && (((12'({1'b0, h_cnt}) + 12'd1) != 12'(H_TOTAL))
                      || (hw_cnt != CW'(H_SYNC)));
        // A line failing on the vsync tick still belongs to the closing frame.
        // The coincident hsync edge is the line that the +1 accounts for.
        frame_good = !(frame_bad || line_fail)
                  && ((12'({1'b0, line_cnt}) + 12'd1) == 12'(V_TOTAL));
        tmo        = pix_en && !h_lead && (h_nxt >= CW'(TMO_TICKS));
    end

    // Edge registers, counters and period measurements
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            h_cnt    <= '0;
            hw_cnt   <= '0;
            line_cnt <= '0;
            h_period <= '0;
            v_period <= '0;
        end else if (pix_en) begin
            hs_q     <= hs_act;
            vs_q     <= vs_act;
            h_cnt    <= h_nxt;
            line_cnt <= l_pos;

            if (h_lead) begin
                hw_cnt <= CW'(1);
            end else if (hs_act && (hw_cnt != CNT_MAX)) begin
                hw_cnt <= hw_cnt + CW'(1);
            end

            if (h_lead) begin
                h_period <= (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + CW'(1);
            end
            if (v_lead) begin
                v_period <= (line_cnt == CNT_MAX) ? CNT_MAX : line_cnt + CW'(1);
            end
        end
    end

    // Lock FSM with registered position, pulse and frame outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            locked     <= 1'b0;
            active     <= 1'b0;
            x          <= '0;
            y          <= '0;
            line_err   <= 1'b0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
            good_cnt   <= '0;
            frame_bad  <= 1'b0;
            skip_line  <= 1'b0;
        end else begin
            line_err   <= 1'b0;
            frame_done <= 1'b0;

            if (pix_en) begin
                active   <= act_nxt;
                line_err <= line_fail;
                if (act_nxt) begin
                    x <= x_nxt;
                    y <= y_nxt;
                end
                if (line_fail) begin
                    frame_bad <= 1'b1;
                end
                if (h_lead && (state != HUNT)) begin
                    skip_line <= 1'b0;
                end

                if (tmo) begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    active   <= 1'b0;
                    good_cnt <= '0;
                end else if (v_lead) begin
                    unique case (state)
                        HUNT: begin
                            state     <= MEASURE;
                            good_cnt  <= '0;
                            frame_bad <= 1'b0;
                            skip_line <= 1'b1;
                        end
                        MEASURE: begin
                            frame_done <= 1'b1;
                            frame_sum  <= sum;
                            frame_bad  <= 1'b0;
                            if (!frame_good) begin
                                good_cnt <= '0;
                            end else if (good_cnt == 2'(GOOD_NEED - 1)) begin
                                good_cnt <= 2'(GOOD_NEED);
                                state    <= LOCKED;
                                locked   <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + 2'd1;
                            end
                        end
                        LOCKED: begin
                            frame_done <= 1'b1;
                            frame_sum  <= sum;
                            frame_bad  <= 1'b0;
                            if (!frame_good) begin
                                state     <= MEASURE;
                                locked    <= 1'b0;
                                good_cnt  <= '0;
                                skip_line <= 1'b1;
                            end
                        end
                        default: begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Rotate-xor checksum over visible pixels, restarted at each frame
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (pix_en) begin
            if (v_lead) begin
                sum <= '0;
            end else if (act_nxt) begin
                sum <= {sum[14:0], sum[15]} ^ {4'b0, red, green, blue};
            end
        end
    end

`ifdef VGA_BLANK_CHECK_EN
    logic [15:0] blank_cnt;
    logic        blank_viol;

    // Non-black pixel outside the visible window while tracking
    always_comb begin
        blank_viol = (state != HUNT) && !act_nxt && ({red, green, blue} != 12'd0);
    end

    // Per-frame blanking violation counter, saturating, latched at frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_cnt     <= '0;
            blank_err_cnt <= '0;
        end else if (pix_en) begin
            if (v_lead) begin
                if (state != HUNT) begin
                    blank_err_cnt <= blank_cnt;
                end
                blank_cnt <= '0;
            end else if (blank_viol && (blank_cnt != 16'hFFFF)) begin
                blank_cnt <= blank_cnt + 16'd1;
            end
        end
    end
`else
    assign blank_err_cnt = 16'd0;
`endif

endmodule
